// File: rtl/score_display_driver.sv
// score_display_driver: binary score -> BCD (serial shift-add-3) -> multiplexed common-anode digit scan.
// Latency: capture edge to display register SCORE_W+1 cycles; an/digit_val registered 1 cycle after scan index/display.
// Backpressure: none; strobes while busy go to a one-deep pending slot (newest wins) and chain into the next conversion.
// Ports: clk, rst_n (async active-low); score/score_valid (capture strobe); busy (conversion running);
//        digit_val (BCD nibble to segment decoder, 4'hF = blank); an (active-low one-hot digit enables).
module score_display_driver #(
    parameter int NDIGITS  = 4,
    parameter int SCORE_W  = 14,
    parameter int SCAN_DIV = 100000,
    parameter bit LZB      = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [SCORE_W-1:0] score,
    input  logic               score_valid,
    output logic               busy,
    output logic [3:0]         digit_val,
    output logic [NDIGITS-1:0] an
);

    function automatic longint pow10(input int n);
        longint p;
        p = 1;
        for (int i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p;
    endfunction

    localparam int BCD_W = 4 * NDIGITS;
    localparam int SR_W  = BCD_W + SCORE_W;
    localparam int CW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW    = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam int SW    = $clog2(SCORE_W + 1);
    localparam logic [63:0] MAXV = 64'(pow10(NDIGITS) - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } state_t;

    state_t             state;
    logic [SR_W-1:0]    sr;         // {bcd nibbles, binary remainder}
    logic [SW-1:0]      sh_cnt;
    logic               pend;
    logic [SCORE_W-1:0] pend_val;
    logic [BCD_W-1:0]   disp;
    logic [CW-1:0]      scan_cnt;
    logic [IW-1:0]      idx;
    logic [3:0]         cur_nib;
    logic               upper_nz;
    logic               blank;

    // Scores beyond what the digits can show pin to all nines.
    function automatic logic [SCORE_W-1:0] clamp(input logic [SCORE_W-1:0] s);
        if (64'(s) > MAXV) begin
            return MAXV[SCORE_W-1:0];
        end
        return s;
    endfunction

    // One double-dabble step: correct every nibble that would overflow past 9 when doubled, then shift.
    function automatic logic [SR_W-1:0] dabble(input logic [SR_W-1:0] s);
        logic [SR_W-1:0] t;
        t = s;
        for (int d = 0; d < NDIGITS; d++) begin
            if (t[SCORE_W+4*d +: 4] >= 4'd5) begin
                t[SCORE_W+4*d +: 4] = t[SCORE_W+4*d +: 4] + 4'd3;
            end
        end
        return {t[SR_W-2:0], 1'b0};
    endfunction

    // Conversion FSM; disp only changes in LOAD so the scan never sees a partial result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sr       <= '0;
            sh_cnt   <= '0;
            busy     <= 1'b0;
            pend     <= 1'b0;
            pend_val <= '0;
            disp     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (score_valid) begin
                        sr     <= {{BCD_W{1'b0}}, clamp(score)};
                        sh_cnt <= '0;
                        busy   <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr <= dabble(sr);
                    if (score_valid) begin
                        pend     <= 1'b1;
                        pend_val <= clamp(score);
                    end
                    if (sh_cnt == SW'(SCORE_W - 1)) begin
                        state <= LOAD;
                    end else begin
                        sh_cnt <= sh_cnt + SW'(1);
                    end
                end
                LOAD: begin
                    disp   <= sr[SR_W-1 -: BCD_W];
                    sh_cnt <= '0;
                    // A strobe landing on LOAD is newer than anything parked, so it wins outright.
                    if (score_valid) begin
                        sr    <= {{BCD_W{1'b0}}, clamp(score)};
                        pend  <= 1'b0;
                        state <= SHIFT;
                    end else if (pend) begin
                        sr    <= {{BCD_W{1'b0}}, pend_val};
                        pend  <= 1'b0;
                        state <= SHIFT;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Free-running scan timer, independent of conversion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_cnt == CW'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            idx      <= (idx == IW'(NDIGITS - 1)) ? '0 : idx + IW'(1);
        end else begin
            scan_cnt <= scan_cnt + CW'(1);
        end
    end

    // A digit is a leading zero when it and every digit above it are zero; digit 0 always shows.
    always_comb begin
        cur_nib  = 4'h0;
        upper_nz = 1'b0;
        for (int d = 0; d < NDIGITS; d++) begin
            if (IW'(d) == idx) begin
                cur_nib = disp[4*d +: 4];
            end
            if ((IW'(d) >= idx) && (disp[4*d +: 4] != 4'h0)) begin
                upper_nz = 1'b1;
            end
        end
        blank = LZB && (idx != '0) && !upper_nz;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an        <= '1;
            digit_val <= 4'hF;
        end else begin
            an        <= ~(NDIGITS'(1) << idx);
            digit_val <= blank ? 4'hF : cur_nib;
        end
    end

endmodule

// File: doc/score_display_driver.md
Name: score_display_driver

Overview:
- Source side of the 7-segment path: turns a binary game score into per-digit BCD values and scans them across a multiplexed common-anode display.
- Feeds the existing 4-bit-to-segment decoder, one digit at a time through `digit_val`, and drives the digit anodes directly.
- Binary-to-BCD conversion is a serial shift-add-3 (double-dabble) engine. The display register updates atomically, so the display never shows a half-converted value.

Parameters:
- NDIGITS, 4, number of display digits (1..6).
- SCORE_W, 14, binary score width; 4*NDIGITS+SCORE_W ≤ 40.
- SCAN_DIV, 100000, clk cycles each digit stays enabled (≥2).
- LZB, 1, 1 = blank leading zeros; 0 = show all digits.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- score  in  SCORE_W  binary score to display
- score_valid  in  1  one-cycle strobe: sample `score`
- busy  out  1  conversion in progress
- digit_val  out  4  BCD digit to segment decoder; 4'hF = blank (decoder outputs all-off)
- an  out  NDIGITS  active-low digit enables, one-hot-low

Behaviour:
- Reset (async assert, sync release): `an` = all ones; `digit_val` = 4'hF; displayed BCD = 0; scan index = 0; scan counter = 0; `busy` = 0; pending flag clear.
- Capture:
  - `score_valid` sampled on a rising edge while `busy` = 0 loads the shift register.
  - If `score` > 10^NDIGITS−1, load 10^NDIGITS−1 (saturate), e.g. 9999 for NDIGITS=4.
  - `busy` = 1 from the next cycle.
- Conversion FSM, states IDLE → SHIFT → LOAD → IDLE:
  - SHIFT lasts exactly SCORE_W cycles. Each cycle: add 3 to every BCD nibble ≥5, then shift left 1.
  - LOAD is one cycle. It copies the BCD nibbles into the display register and drops `busy` (`busy` = 0 in the cycle after LOAD).
  - Capture edge to display-register update = SCORE_W+1 cycles.
- Valid while busy:
  - Store `score` in the pending register and set the pending flag. A later strobe overwrites it (newest wins).
  - On LOAD, if pending is set: clear it, load the pending value into the shift register, and go straight to SHIFT. `busy` stays 1.
- Valid in the same cycle as LOAD is treated as pending.
- Scanner:
  - Free-running counter 0..SCAN_DIV−1, independent of the conversion FSM.
  - At terminal count the scan index advances by 1, wrapping NDIGITS−1 → 0.
- Outputs are registered, 1 cycle after the index/display register:
  - `an` = ~(1 << index). Digit 0 is least significant.
  - `digit_val` = display nibble[index].
  - First cycle after reset release: `an` goes to ~1.
- Leading-zero blanking (LZB=1):
  - A digit at an index above the most significant nonzero nibble outputs 4'hF.
  - Digit 0 is never blanked, so score 0 shows a single "0".
- A display-register update mid-scan takes effect on the next registered output cycle. No scan restart.
- Reset mid-conversion aborts it: pending discarded, display returns to 0.

Test Plan:
- Reset, SCAN_DIV=4, no valid → first cycle after release `an`=4'b1110, `digit_val`=0 (LZB); `an` rotates 1110→1101→1011→0111→1110 every 4 cycles; `digit_val` = F on digits 1..3.
- `score`=1234 strobe → `busy` high exactly 15 cycles; display then shows 4,3,2,1 on `an` 1110,1101,1011,0111.
- `score`=12000 → saturates; digits read 9,9,9,9. `score`=7 with LZB=1 → 7,F,F,F; with LZB=0 → 7,0,0,0.
- Strobes 5, then 42 and 300 during the first conversion → display goes 5 then 300, never 42; `busy` continuous for 2×15 cycles.
- Strobe coincident with LOAD (`score`=88 while converting 1) → display 1, then 88 after a further SCORE_W+1 cycles.
- Assert `rst_n` low mid-SHIFT of 4321 → `an` all ones and `busy` 0 immediately (async); after release display shows 0; no late 4321 appears.
